// File: rtl/kbd_ctrl_pkg.sv
// Shared constants and types for the keyboard transport controller:
// ASCII command codes, transport states and the one-hot command vector.
package kbd_ctrl_pkg;

  localparam logic [7:0] KEY_E = 8'h65;  // play / resume
  localparam logic [7:0] KEY_D = 8'h64;  // pause
  localparam logic [7:0] KEY_B = 8'h62;  // backward
  localparam logic [7:0] KEY_F = 8'h66;  // forward
  localparam logic [7:0] KEY_R = 8'h72;  // restart
  localparam logic [7:0] KEY_U = 8'h75;  // faster
  localparam logic [7:0] KEY_S = 8'h73;  // slower
  localparam logic [7:0] KEY_N = 8'h6E;  // normal speed
  localparam logic [7:0] KEY_O = 8'h6F;  // toggle loop

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_RESTART = 2'd3
  } state_e;

  localparam int CMD_N       = 9;
  localparam int CMD_PLAY    = 0;
  localparam int CMD_PAUSE   = 1;
  localparam int CMD_BACK    = 2;
  localparam int CMD_FWD     = 3;
  localparam int CMD_RESTART = 4;
  localparam int CMD_FASTER  = 5;
  localparam int CMD_SLOWER  = 6;
  localparam int CMD_NORMAL  = 7;
  localparam int CMD_LOOP    = 8;

  typedef logic [CMD_N-1:0] cmd_t;

endpackage

// File: rtl/kbd_transport_ctrl_if.sv
// Keyboard-side inputs and address-FSM/rate-divider outputs of the transport
// controller, bundled as one interface.
interface kbd_transport_ctrl_if #(
  parameter int SPEED_W = 32
);
  logic               kbd_data_ready;
  logic [7:0]         key;
  logic               finish;
  logic               end_of_song;
  logic               start;
  logic               restart;
  logic               FWD;
  logic               loop_en;
  logic [SPEED_W-1:0] speed_div;
  logic               key_ack;
  logic               restart_to;

  modport master (
    output kbd_data_ready, key, finish, end_of_song,
    input  start, restart, FWD, loop_en, speed_div, key_ack, restart_to
  );

  modport slave (
    input  kbd_data_ready, key, finish, end_of_song,
    output start, restart, FWD, loop_en, speed_div, key_ack, restart_to
  );
endinterface

// File: rtl/kbd_cmd_decode.sv
// Combinational key decoder: folds upper-case letters to lower case and maps
// the result onto a one-hot command vector.
module kbd_cmd_decode
  import kbd_ctrl_pkg::*;
(
  input  logic [7:0] key,
  output cmd_t       cmd,
  output logic       cmd_vld
);

  logic [7:0] key_lc;

  always_comb begin
    key_lc = key;
    if ((key >= 8'h41) && (key <= 8'h5A)) key_lc = key | 8'h20;
    cmd = '0;
    case (key_lc)
      KEY_E:   cmd[CMD_PLAY]    = 1'b1;
      KEY_D:   cmd[CMD_PAUSE]   = 1'b1;
      KEY_B:   cmd[CMD_BACK]    = 1'b1;
      KEY_F:   cmd[CMD_FWD]     = 1'b1;
      KEY_R:   cmd[CMD_RESTART] = 1'b1;
      KEY_U:   cmd[CMD_FASTER]  = 1'b1;
      KEY_S:   cmd[CMD_SLOWER]  = 1'b1;
      KEY_N:   cmd[CMD_NORMAL]  = 1'b1;
      KEY_O:   cmd[CMD_LOOP]    = 1'b1;
      default: cmd = '0;
    endcase
    cmd_vld = |cmd;
  end

endmodule

// File: rtl/kbd_transport_ctrl.sv
// Keyboard transport controller: key edge detect, transport FSM, playback
// rate and loop registers, and the restart watchdog.
module kbd_transport_ctrl
  import kbd_ctrl_pkg::*;
#(
  parameter int                 SPEED_W       = 32,
  parameter logic [SPEED_W-1:0] SPEED_DEFAULT = 32'd1136,
  parameter logic [SPEED_W-1:0] SPEED_STEP    = 32'd64,
  parameter logic [SPEED_W-1:0] SPEED_MIN     = 32'd256,
  parameter logic [SPEED_W-1:0] SPEED_MAX     = 32'd8192,
  parameter int                 TO_W          = 16,
  parameter logic [TO_W-1:0]    RESTART_TO    = 16'd1024
) (
  input logic                 clk,
  input logic                 reset,
  kbd_transport_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] PLAY    = ST_PLAY;
  localparam logic [1:0] PAUSE   = ST_PAUSE;
  localparam logic [1:0] RESTART = ST_RESTART;

  logic [1:0]         state, state_nx;
  logic               dir, dir_nx;
  logic               loop_en;
  logic [SPEED_W-1:0] speed_div;
  logic [TO_W-1:0]    wd;
  logic               rdy_p1, armed;
  logic               key_ack, restart_to, to_fire;
  logic               accept;
  cmd_t               cmd;
  logic               cmd_vld;

  function automatic logic [SPEED_W-1:0] sat_dec(input logic [SPEED_W-1:0] v);
    return (v < SPEED_MIN + SPEED_STEP) ? SPEED_MIN : v - SPEED_STEP;
  endfunction

  function automatic logic [SPEED_W-1:0] sat_inc(input logic [SPEED_W-1:0] v);
    return (v > SPEED_MAX - SPEED_STEP) ? SPEED_MAX : v + SPEED_STEP;
  endfunction

  kbd_cmd_decode u_dec (
    .key     (bus.key),
    .cmd     (cmd),
    .cmd_vld (cmd_vld)
  );

  // armed stays low after reset until ready is seen low, so a key held across reset never fires
  assign accept = bus.kbd_data_ready & ~rdy_p1 & armed;

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    to_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && cmd[CMD_PLAY]) begin
          state_nx = PLAY;
          dir_nx   = 1'b1;
        end else if (accept && cmd[CMD_BACK]) begin
          state_nx = PLAY;
          dir_nx   = 1'b0;
        end
      end
      PLAY: begin
        // end of song takes priority and swallows any transport key of the same cycle
        if (bus.end_of_song) begin
          state_nx = loop_en ? RESTART : PAUSE;
        end else if (accept) begin
          if (cmd[CMD_PAUSE])   state_nx = PAUSE;
          if (cmd[CMD_RESTART]) state_nx = RESTART;
          if (cmd[CMD_BACK])    dir_nx   = 1'b0;
          if (cmd[CMD_FWD])     dir_nx   = 1'b1;
        end
      end
      PAUSE: begin
        if (accept) begin
          if (cmd[CMD_PLAY])    state_nx = PLAY;
          if (cmd[CMD_RESTART]) state_nx = RESTART;
          if (cmd[CMD_BACK])    dir_nx   = 1'b0;
          if (cmd[CMD_FWD])     dir_nx   = 1'b1;
        end
      end
      RESTART: begin
        if (bus.finish) begin
          state_nx = PLAY;
        end else if (wd == RESTART_TO - 1'b1) begin
          state_nx = PLAY;
          to_fire  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= 1'b0;
      loop_en    <= 1'b0;
      speed_div  <= SPEED_DEFAULT;
      wd         <= '0;
      rdy_p1     <= 1'b0;
      armed      <= 1'b0;
      key_ack    <= 1'b0;
      restart_to <= 1'b0;
    end else begin
      rdy_p1     <= bus.kbd_data_ready;
      if (!bus.kbd_data_ready) armed <= 1'b1;
      state      <= state_nx;
      dir        <= dir_nx;
      key_ack    <= accept & cmd_vld;
      restart_to <= to_fire;
      wd         <= (state == RESTART && state_nx == RESTART) ? wd + 1'b1 : '0;
      if (accept) begin
        if (cmd[CMD_FASTER])      speed_div <= sat_dec(speed_div);
        else if (cmd[CMD_SLOWER]) speed_div <= sat_inc(speed_div);
        else if (cmd[CMD_NORMAL]) speed_div <= SPEED_DEFAULT;
        if (cmd[CMD_LOOP]) loop_en <= ~loop_en;
      end
    end
  end

  assign bus.start      = (state == PLAY) || (state == RESTART);
  assign bus.restart    = (state == RESTART);
  assign bus.FWD        = dir;
  assign bus.loop_en    = loop_en;
  assign bus.speed_div  = speed_div;
  assign bus.key_ack    = key_ack;
  assign bus.restart_to = restart_to;

endmodule

// File: tb/tb_kbd_transport_ctrl.sv
// Directed bench for kbd_transport_ctrl: expected outputs are queued with each
// command and checked by a monitor whenever key_ack or restart_to pulses.
module tb_kbd_transport_ctrl;

  logic clk = 1'b0;
  logic reset;

  kbd_transport_ctrl_if #(.SPEED_W(32)) bus ();

  kbd_transport_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        kind;  // 0 = key_ack, 1 = restart_to
    logic [35:0] outs;  // {start, restart, FWD, loop_en, speed_div}
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt;
  int   guard;

  function automatic logic [35:0] snap();
    return {bus.start, bus.restart, bus.FWD, bus.loop_en, bus.speed_div};
  endfunction

  function automatic logic [35:0] ov(input logic s, input logic r, input logic f,
                                     input logic l, input int sp);
    return {s, r, f, l, sp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop(input logic kind, input string name);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected pulse, outputs %0h, expected no pulse", name, snap());
    end else begin
      e = q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk(name, snap(), e.outs);
    end
  endtask

  // Monitor: every output pulse consumes one queued expectation
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.restart_to) pop(1'b1, "restart_to");
      if (bus.key_ack)    pop(1'b0, "key_ack");
    end
  end

  task automatic press(input logic [7:0] k, input bit ack, input logic [35:0] e);
    if (ack) q.push_back(exp_t'{kind: 1'b0, outs: e});
    bus.key = k;
    bus.kbd_data_ready = 1'b1;
    @(posedge clk); #1;
    bus.kbd_data_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic eos_pulse();
    bus.end_of_song = 1'b1;
    @(posedge clk); #1;
    bus.end_of_song = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d compared, expected completion", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    bus.kbd_data_ready = 1'b0;
    bus.key            = 8'h00;
    bus.finish         = 1'b0;
    bus.end_of_song    = 1'b0;
    reset              = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", snap(), ov(0, 0, 0, 0, 1136));
    chk("reset_pulses", {bus.key_ack, bus.restart_to}, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Play forward, then backward; unknown key ignored
    press("E", 1, ov(1, 0, 1, 0, 1136));
    repeat (3) @(posedge clk); #1;
    press("b", 1, ov(1, 0, 0, 0, 1136));
    press("x", 0, '0);
    press("f", 1, ov(1, 0, 1, 0, 1136));

    // Held key counts once
    q.push_back(exp_t'{kind: 1'b0, outs: ov(1, 0, 1, 0, 1072)});
    bus.key = "u";
    bus.kbd_data_ready = 1'b1;
    repeat (50) @(posedge clk); #1;
    bus.kbd_data_ready = 1'b0;
    @(posedge clk); #1;
    chk("held_u_speed", bus.speed_div, 1072);

    // Slower saturates at the maximum, faster at the minimum
    for (int i = 1; i <= 200; i++)
      press("s", 1, ov(1, 0, 1, 0, (1072 + 64 * i > 8192) ? 8192 : 1072 + 64 * i));
    chk("sat_max", bus.speed_div, 8192);
    press("n", 1, ov(1, 0, 1, 0, 1136));
    for (int i = 1; i <= 15; i++)
      press("U", 1, ov(1, 0, 1, 0, (1136 - 64 * i < 256) ? 256 : 1136 - 64 * i));
    chk("sat_min", bus.speed_div, 256);
    press("N", 1, ov(1, 0, 1, 0, 1136));

    // Restart without finish: watchdog forces PLAY
    q.push_back(exp_t'{kind: 1'b0, outs: ov(1, 1, 1, 0, 1136)});
    q.push_back(exp_t'{kind: 1'b1, outs: ov(1, 0, 1, 0, 1136)});
    bus.key = "r";
    bus.kbd_data_ready = 1'b1;
    @(posedge clk); #1;
    bus.kbd_data_ready = 1'b0;
    cnt   = 0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (bus.restart) cnt++;
    end while (bus.restart && guard < 2000);
    chk("restart_cycles", cnt, 1024);
    chk("after_timeout", snap(), ov(1, 0, 1, 0, 1136));
    @(posedge clk); #1;

    // Loop on end of song, then pause on end of song
    press("o", 1, ov(1, 0, 1, 1, 1136));
    eos_pulse();
    @(negedge clk);
    chk("eos_loop", snap(), ov(1, 1, 1, 1, 1136));
    bus.finish = 1'b1;
    @(posedge clk); #1;
    bus.finish = 1'b0;
    @(negedge clk);
    chk("finish_play", snap(), ov(1, 0, 1, 1, 1136));
    @(posedge clk); #1;
    press("O", 1, ov(1, 0, 1, 0, 1136));
    eos_pulse();
    @(negedge clk);
    chk("eos_pause", snap(), ov(0, 0, 1, 0, 1136));
    @(posedge clk); #1;
    press("b", 1, ov(0, 0, 0, 0, 1136));
    press("e", 1, ov(1, 0, 0, 0, 1136));
    press("f", 1, ov(1, 0, 1, 0, 1136));
    press("o", 1, ov(1, 0, 1, 1, 1136));

    // Pause key and end of song together: end of song wins
    q.push_back(exp_t'{kind: 1'b0, outs: ov(1, 1, 1, 1, 1136)});
    bus.key = "d";
    bus.kbd_data_ready = 1'b1;
    bus.end_of_song = 1'b1;
    @(posedge clk); #1;
    bus.kbd_data_ready = 1'b0;
    bus.end_of_song = 1'b0;
    @(posedge clk); #1;
    press("b", 1, ov(1, 1, 1, 1, 1136));
    press("u", 1, ov(1, 1, 1, 1, 1072));

    // Async reset mid-RESTART with a key held across it
    bus.key = "e";
    bus.kbd_data_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outs", snap(), ov(0, 0, 0, 0, 1136));
    chk("async_reset_pulses", {bus.key_ack, bus.restart_to}, 0);
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("held_after_reset", snap(), ov(0, 0, 0, 0, 1136));
    bus.kbd_data_ready = 1'b0;
    @(posedge clk); #1;
    press("e", 1, ov(1, 0, 1, 0, 1136));
    repeat (2) @(posedge clk); #1;
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
